// File: rtl/duty_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : duty_gen_if
// Description : Control/status bundle between a duty-cycle generator and its
//               controller: run request, configuration load, waveform and
//               status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface duty_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic          load;
  logic [CW-1:0] period_in;
  logic [CW-1:0] high_in;
  logic          ft;
  logic          cyc_done;
  logic          active;
  logic          cfg_err;

  // Controller side: issues requests and configuration, observes status.
  modport master (
    output en, load, period_in, high_in,
    input  ft, cyc_done, active, cfg_err
  );

  // Generator side.
  modport slave (
    input  en, load, period_in, high_in,
    output ft, cyc_done, active, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/duty_gen.sv
`default_nettype none
// ============================================================================
// Module      : duty_gen
// Description : Programmable period/high-time waveform generator. Loads are
//               validated, held pending and applied only at period
//               boundaries (or immediately while idle), so every emitted
//               period is complete and uses a single (P,H) pair. Stopping
//               lets the current period finish.
// Revision    : 1.0 - initial release
// ============================================================================
module duty_gen #(
  parameter int CW   = 10,
  parameter int PMIN = 20,
  parameter int PMAX = 500
) (
  input  logic      inclk0,
  input  logic      rst_n,
  duty_gen_if.slave bus
);

  localparam logic [CW-1:0] c_pmin = CW'(PMIN);
  localparam logic [CW-1:0] c_pmax = CW'(PMAX);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_pa;
  logic [CW-1:0] r_ha;
  logic [CW-1:0] r_pn;
  logic [CW-1:0] r_hn;
  logic          r_pend;
  logic          r_ok;
  logic          r_err;
  logic          r_ft;
  logic          r_cyc_done;
  logic          r_active;

  logic          w_accept;
  logic          w_reject;
  logic          w_last;
  logic          w_take_pend;
  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_nxt_pa;
  logic [CW-1:0] w_nxt_ha;

  // A load is legal only with an in-range period and a high time that fits.
  assign w_accept = bus.load
                  && (bus.period_in >= c_pmin)
                  && (bus.period_in <= c_pmax)
                  && (bus.high_in   <= bus.period_in);
  assign w_reject = bus.load && !w_accept;

  // Last cycle of the current period; Pa is never below PMIN while running.
  assign w_last = (r_cnt == (r_pa - c_one));

  // Next state, counter and active pair; pending data is taken while idle or
  // at a period boundary, using the pend value present at the start of the
  // cycle so a load landing in the boundary cycle waits one more period.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_pa    = r_pa;
    w_nxt_ha    = r_ha;
    w_take_pend = 1'b0;
    case (r_state)
      IDLE: begin
        w_nxt_cnt = '0;
        if (r_pend) begin
          w_nxt_pa    = r_pn;
          w_nxt_ha    = r_hn;
          w_take_pend = 1'b1;
        end
        if (bus.en && r_ok) begin
          w_nxt_state = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_nxt_cnt = '0;
          if (r_pend) begin
            w_nxt_pa    = r_pn;
            w_nxt_ha    = r_hn;
            w_take_pend = 1'b1;
          end
          if (!bus.en) begin
            w_nxt_state = IDLE;
          end
        end else begin
          w_nxt_cnt = r_cnt + c_one;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // State, configuration registers and outputs; outputs are computed from
  // next-cycle values so they line up with the registered counter.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pa       <= '0;
      r_ha       <= '0;
      r_pn       <= '0;
      r_hn       <= '0;
      r_pend     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_ft       <= 1'b0;
      r_cyc_done <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_pa    <= w_nxt_pa;
      r_ha    <= w_nxt_ha;

      if (w_accept) begin
        r_pn   <= bus.period_in;
        r_hn   <= bus.high_in;
        r_pend <= 1'b1;
        r_ok   <= 1'b1;
        r_err  <= 1'b0;
      end else begin
        if (w_take_pend) begin
          r_pend <= 1'b0;
        end
        if (w_reject) begin
          r_err <= 1'b1;
        end
      end

      r_ft       <= (w_nxt_state == RUN) && (w_nxt_cnt < w_nxt_ha);
      r_cyc_done <= (w_nxt_state == RUN) && (w_nxt_cnt == (w_nxt_pa - c_one));
      r_active   <= (w_nxt_state == RUN);
    end
  end

  assign bus.ft       = r_ft;
  assign bus.cyc_done = r_cyc_done;
  assign bus.active   = r_active;
  assign bus.cfg_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_duty_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_gen
// Description : Scoreboard bench for duty_gen: the stimulus process runs a
//               period-level reference model and queues expected outputs; a
//               monitor process compares them one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_gen;

  localparam int CW   = 10;
  localparam int PMIN = 20;
  localparam int PMAX = 500;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  duty_gen_if #(.CW(CW)) dif ();

  duty_gen #(.CW(CW), .PMIN(PMIN), .PMAX(PMAX)) dut (
    .inclk0 (clk),
    .rst_n  (rst_n),
    .bus    (dif.slave)
  );

  typedef struct packed {
    logic ft;
    logic cd;
    logic act;
    logic err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: running flag, position within the current period,
  // active and pending (period, high) pairs, and status flags.
  bit m_run;
  int m_pos;
  int m_pa, m_ha, m_pn, m_hn;
  bit m_pend, m_ok, m_err;

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    m_pa = 0; m_ha = 0; m_pn = 0; m_hn = 0;
    m_pend = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int p, input int h);
    bit acc;
    acc = l && (p >= PMIN) && (p <= PMAX) && (h <= p);
    if (!m_run) begin
      if (m_pend) begin
        m_pa = m_pn; m_ha = m_hn; m_pend = 0;
      end
      if (e && m_ok) begin
        m_run = 1; m_pos = 0;
      end
    end else if (m_pos == m_pa - 1) begin
      if (m_pend) begin
        m_pa = m_pn; m_ha = m_hn; m_pend = 0;
      end
      m_pos = 0;
      if (!e) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    if (acc) begin
      m_pn = p; m_hn = h; m_pend = 1; m_ok = 1; m_err = 0;
    end else if (l) begin
      m_err = 1;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, advance the model
  // across the coming rising edge and queue what the DUT must then show.
  task automatic step(input bit r, input bit e, input bit l, input int p, input int h);
    exp_t x;
    @(negedge clk);
    rst_n         = r;
    dif.en        = e;
    dif.load      = l;
    dif.period_in = p[CW-1:0];
    dif.high_in   = h[CW-1:0];
    if (!r) model_reset();
    else    model_edge(e, l, p, h);
    x.ft  = m_run && (m_pos < m_ha);
    x.cd  = m_run && (m_pos == m_pa - 1);
    x.act = m_run;
    x.err = m_err;
    q.push_back(x);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(1, e, 0, 0, 0);
  endtask

  // Assert reset between edges and confirm ft drops with no clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (dif.ft !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_ft: got=%b want=0", dif.ft);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin : monitor
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        me = q.pop_front();
        total++;
        if ({dif.ft, dif.cyc_done, dif.active, dif.cfg_err} !== me) begin
          bad++;
          $display("FAIL outputs cyc=%0d ft/cyc_done/active/cfg_err got=%b%b%b%b want=%b%b%b%b",
                   cyc, dif.ft, dif.cyc_done, dif.active, dif.cfg_err,
                   me.ft, me.cd, me.act, me.err);
        end
      end
    end
  end

  initial begin : stimulus
    int p, h, sel;
    bit e;
    dif.en = 0; dif.load = 0; dif.period_in = '0; dif.high_in = '0;
    model_reset();

    // Reset state, then a run request with no configuration stays idle.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    run(5, 1);

    // Basic 100/25 operation.
    step(1, 0, 1, 100, 25);
    run(250, 1);
    // Reconfigure mid-period to 40/30.
    step(1, 1, 1, 40, 30);
    run(200, 1);
    // Rejected loads, then a valid one.
    step(1, 1, 1, 10, 5);
    run(3, 1);
    step(1, 1, 1, 100, 600);
    run(3, 1);
    step(1, 1, 1, 50, 10);
    run(120, 1);
    // High time zero, then high time equal to period.
    step(1, 1, 1, 200, 0);
    run(450, 1);
    step(1, 1, 1, 200, 200);
    run(450, 1);
    // Boundary-sized periods.
    step(1, 1, 1, PMIN, 7);
    run(70, 1);
    step(1, 1, 1, PMAX, PMAX - 1);
    run(20, 1);
    step(1, 1, 1, 100, 25);
    run(520, 1);
    // Stop mid-period, let it finish, restart.
    run(30, 0);
    run(10, 1);
    run(150, 0);
    run(60, 1);
    // Reset during the high phase; run request without reload stays idle.
    step(1, 1, 1, 100, 25);
    run(110, 1);
    async_reset_check();
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    run(20, 1);

    // Randomized loads and run/stop toggling.
    e = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) e = ~e;
      if ($urandom_range(0, 29) == 0) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0: p = PMIN;
          1: p = PMAX;
          2: p = PMIN - 1;
          3: p = PMAX + 1;
          default: p = $urandom_range(PMIN, 80);
        endcase
        sel = $urandom_range(0, 5);
        case (sel)
          0: h = 0;
          1: h = p;
          2: h = p + 1;
          default: h = $urandom_range(0, p);
        endcase
        step(1, e, 1, p, h);
      end else begin
        step(1, e, 0, 0, 0);
      end
    end

    run(3, 0);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got=%0d left want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
